// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared types and elaboration helpers for pipelined_adder.
//   stage_ctl_t  - per-stage control record (valid, carry), embedded in the
//                  data-carrying stage record declared by the top module
//   slice_w      - bits handled by one pipeline slice
//   params_legal - WIDTH/STAGES legality check used at elaboration
package pipelined_adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? width / stages : 1;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple-carry adder, one per pipeline stage.
//   a, b  - slice operands
//   cin   - carry into bit 0 of the slice
//   sum   - a + b + cin, low W bits
//   cout  - carry out of bit W-1
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES ripple slices, one
// register boundary per slice, valid/ready handshake on both sides.
//   clk_i, rst_n        - clock (rising edge), async active-low reset
//   valid_i / ready_o   - operand pair handshake
//   src1_i, src2_i,cin_i- operands and carry-in
//   valid_o / ready_i   - result handshake
//   sum_o, cout_o       - registered sum and carry-out
//   ovf_o               - signed overflow, only when PIPE_ADDER_OVF_EN is defined
// Each stage register holds: valid, carry, finished low sum bits and the
// still-pending high operand bits. The last stage register is the output.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
`ifdef PIPE_ADDER_OVF_EN
    output logic             cout_o,
    output logic             ovf_o
`else
    output logic             cout_o
`endif
);
    localparam int SW   = slice_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t [STAGES-1:0] st_q;
    logic   [STAGES-1:0] en;    // stage k may load this edge

    // A stage loads when it is empty or its contents move on; the chain
    // starts at the output handshake so bubbles anywhere collapse.
    always_comb begin
        en       = '0;
        en[LAST] = !st_q[LAST].ctl.valid || ready_i;
        for (int k = LAST - 1; k >= 0; k--)
            en[k] = !st_q[k].ctl.valid || en[k+1];
    end

    assign ready_o = en[0];

`ifdef PIPE_ADDER_OVF_EN
    logic last_a_msb, last_b_msb, last_s_msb, last_vld;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        src;
        stage_t        nxt;
        logic [SW-1:0] s_slice;
        logic          c_slice;

        if (k == 0) begin : g_head
            always_comb begin
                src           = '0;
                src.ctl.valid = valid_i;
                src.ctl.carry = cin_i;
                src.a         = src1_i;
                src.b         = src2_i;
            end
        end else begin : g_body
            assign src = st_q[k-1];
        end

        adder_slice #(.W(SW)) u_slice (
            .a    (src.a[k*SW +: SW]),
            .b    (src.b[k*SW +: SW]),
            .cin  (src.ctl.carry),
            .sum  (s_slice),
            .cout (c_slice)
        );

        always_comb begin
            nxt                   = src;
            nxt.ctl.carry         = c_slice;
            nxt.sum[k*SW +: SW]   = s_slice;
            // operand bits at or below this slice are consumed
            nxt.a[(k+1)*SW-1:0]   = '0;
            nxt.b[(k+1)*SW-1:0]   = '0;
        end

        // Bubbles only clear the valid bit; data and carry are left alone.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n)
                st_q[k] <= '0;
            else if (en[k] && src.ctl.valid)
                st_q[k] <= nxt;
            else if (en[k])
                st_q[k].ctl.valid <= 1'b0;
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == LAST) begin : g_sign
            assign last_a_msb = src.a[WIDTH-1];
            assign last_b_msb = src.b[WIDTH-1];
            assign last_s_msb = s_slice[SW-1];
            assign last_vld   = src.ctl.valid;
        end
`endif
    end

    assign valid_o = st_q[LAST].ctl.valid;
    assign sum_o   = st_q[LAST].sum;
    assign cout_o  = st_q[LAST].ctl.carry;

    // Pending-operand fields of the last stage are always empty.
    logic unused_tail;
    assign unused_tail = ^{st_q[LAST].a, st_q[LAST].b};

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (en[LAST] && last_vld)
            ovf_q <= (last_a_msb == last_b_msb) && (last_s_msb != last_a_msb);
    end
    assign ovf_o = ovf_q;
`endif

endmodule
